// File: rtl/code_run_packer.sv
// code_run_packer: collapses runs of equal input codes into (code, length) tokens behind a small FIFO.
// Optional macro CODE_RUN_PACKER_DROP_CNT_EN adds an 8-bit saturating drop_cnt output.
module code_run_packer #(
    parameter int CODE_W = 3,
    parameter int LEN_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [LEN_W-1:0]  out_len,
    output logic              busy
`ifdef CODE_RUN_PACKER_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] MAXLEN = '1;
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state;
    logic [CODE_W-1:0] run_code;
    logic [LEN_W-1:0]  run_len;
    logic [CODE_W-1:0] code_mem [DEPTH];
    logic [LEN_W-1:0]  len_mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              empty, full, pop, push_req, push, drop, extend;
    logic [CODE_W-1:0] push_code;
    logic [LEN_W-1:0]  push_len;

    // Decide whether this cycle closes a run, and which token it produces
    always_comb begin
        extend    = in_valid && (in_code == run_code) && (run_len != MAXLEN);
        push_req  = 1'b0;
        push_code = run_code;
        push_len  = run_len;
        case (state)
            IDLE: begin
                push_req  = in_valid && flush;
                push_code = in_code;
                push_len  = ONE;
            end
            RUN: begin
                push_req = extend ? flush : (in_valid || flush);
                push_len = extend ? run_len + ONE : run_len;
            end
            FLUSH:   push_req = 1'b1;
            default: push_req = 1'b0;
        endcase
    end

    // FIFO status; a push into a full FIFO survives only if the head leaves on the same edge
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        out_valid = !empty;
        pop       = out_valid && out_ready;
        push      = push_req && (!full || pop);
        drop      = push_req && !push;
        out_code  = empty ? '0 : code_mem[rd_ptr[AW-1:0]];
        out_len   = empty ? '0 : len_mem[rd_ptr[AW-1:0]];
        busy      = (state != IDLE) || !empty;
    end

    // Run-tracking FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            run_code <= '0;
            run_len  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid && !flush) begin
                    run_code <= in_code;
                    run_len  <= ONE;
                    state    <= RUN;
                end
                RUN: if (extend) begin
                    run_len <= run_len + ONE;
                    if (flush) state <= IDLE;
                end else if (in_valid) begin
                    run_code <= in_code;
                    run_len  <= ONE;
                    state    <= flush ? FLUSH : RUN;
                end else if (flush) begin
                    state <= IDLE;
                end
                FLUSH: if (in_valid) begin
                    run_code <= in_code;
                    run_len  <= ONE;
                    state    <= RUN;
                end else begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers; they carry one extra bit so full and empty are distinguishable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; stale entries are masked by empty on the outputs, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            code_mem[wr_ptr[AW-1:0]] <= push_code;
            len_mem[wr_ptr[AW-1:0]]  <= push_len;
        end
    end

`ifdef CODE_RUN_PACKER_DROP_CNT_EN
    // Saturating count of dropped tokens, cleared by a drop-free flush cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else if (drop) drop_cnt <= (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
        else if (flush) drop_cnt <= '0;
    end
`endif
endmodule

// File: tb/tb_code_run_packer.sv
// tb_code_run_packer: scoreboard bench for code_run_packer using directed token sequences.
module tb_code_run_packer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = '0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [2:0] out_code;
    logic [3:0] out_len;
    logic       busy;
`ifdef CODE_RUN_PACKER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int total = 0;
    int bad = 0;
    logic [6:0] exp_q[$];

    code_run_packer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_len(out_len),
        .busy(busy)
`ifdef CODE_RUN_PACKER_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic expect_tok(input int code, input int len);
        exp_q.push_back({3'(code), 4'(len)});
    endtask

    task automatic step(input logic v, input int c, input logic f, input logic r);
        in_valid  = v;
        in_code   = 3'(c);
        flush     = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            step(1'b0, 0, 1'b0, 1'b1);
            n++;
        end
        check("drain_timeout", n < 40, 1);
    endtask

    // Monitor: every accepted token is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_token", {out_code, out_len}, 0);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                check("tok_code", out_code, e[6:4]);
                check("tok_len", out_len, e[3:0]);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_code", out_code, 0);
        check("rst_out_len", out_len, 0);
        rst_n = 1'b1;

        // Reset in the middle of an open run discards it
        repeat (3) step(1'b1, 5, 1'b0, 1'b1);
        check("run_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_tok(5, 2);
        repeat (2) step(1'b1, 5, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        drain();

        // Run splitting and push latency
        expect_tok(2, 3);
        expect_tok(6, 2);
        repeat (3) step(1'b1, 2, 1'b0, 1'b1);
        check("lat_before", out_valid, 0);
        step(1'b1, 6, 1'b0, 1'b1);
        check("lat_after", out_valid, 1);
        step(1'b1, 6, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        drain();

        // Length saturation at 15
        expect_tok(3, 15);
        expect_tok(3, 2);
        repeat (17) step(1'b1, 3, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        drain();

        // Code change together with flush goes through FLUSH
        expect_tok(1, 4);
        expect_tok(7, 1);
        repeat (4) step(1'b1, 1, 1'b0, 1'b1);
        step(1'b1, 7, 1'b1, 1'b1);
        check("flush_state_busy", busy, 1);
        step(1'b0, 0, 1'b0, 1'b1);
        drain();
        check("idle_after_flush", busy, 0);

        // Full FIFO with no consumer: last two tokens are dropped
        expect_tok(0, 1);
        expect_tok(1, 1);
        expect_tok(0, 1);
        expect_tok(1, 1);
        for (int i = 0; i < 6; i++) step(1'b1, i % 2, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        check("full_hold_valid", out_valid, 1);
        check("full_hold_code", out_code, 0);
        check("full_hold_len", out_len, 1);
`ifdef CODE_RUN_PACKER_DROP_CNT_EN
        check("drop_cnt_two", drop_cnt, 2);
`endif
        repeat (4) step(1'b0, 0, 1'b0, 1'b1);
        check("full_drained_valid", out_valid, 0);
        check("full_drained_q", exp_q.size(), 0);

        // Push into a full FIFO on a popping cycle is not dropped
        for (int c = 2; c <= 7; c++) expect_tok(c, 1);
        for (int c = 2; c <= 6; c++) step(1'b1, c, 1'b0, 1'b0);
        step(1'b1, 7, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        drain();
`ifdef CODE_RUN_PACKER_DROP_CNT_EN
        check("drop_cnt_cleared", drop_cnt, 0);
`endif
        check("final_busy", busy, 0);
        check("final_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
